// File: rtl/thermal_bit_receiver.sv
// Thermal covert-channel receiver: counts edges of a pre-divided sensor RO
// over fixed windows, thresholds each count into one bit, packs bits into frames.
module thermal_bit_receiver #(
  parameter int unsigned WINDOW_CYCLES = 1000000,
  parameter int unsigned COUNT_W       = 24,
  parameter int unsigned FRAME_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ro_in,
  output logic                  sensor_en,
  input  logic                  start,
  input  logic                  cont,
  input  logic [COUNT_W-1:0]    thr,
  output logic [COUNT_W-1:0]    last_count,
  output logic                  count_valid,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy
);

  localparam int unsigned WinW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StDecide, StHold} state_e;

  state_e                state_q, state_d;
  logic                  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WinW-1:0]       win_q, win_d;
  logic [COUNT_W-1:0]    cnt_q, cnt_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [COUNT_W-1:0]    last_count_q, last_count_d;
  logic                  count_valid_q, count_valid_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;

  logic                  ro_edge;
  logic [COUNT_W-1:0]    cnt_base;
  logic                  dec_bit;
  logic [FRAME_BITS-1:0] shift_nxt;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      win_q         <= '0;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      last_count_q  <= '0;
      count_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      last_count_q  <= last_count_d;
      count_valid_q <= count_valid_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Next-state logic: synchronizer, window/edge counters, decision and framing
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    last_count_d  = last_count_q;
    count_valid_d = 1'b0;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;

    s1_d    = ro_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    ro_edge = s2_q & ~s3_q;

    // Count restarts on the first window cycle so every MEASURE cycle's edge is seen
    cnt_base  = (win_q == '0) ? '0 : cnt_q;
    dec_bit   = (cnt_q < thr);  // hot -> fewer edges -> 1
    shift_nxt = (shift_q << 1) | FRAME_BITS'(dec_bit);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StMeasure;
          win_d     = '0;
          bit_idx_d = '0;
          shift_d   = '0;
        end
      end
      StMeasure: begin
        win_d = win_q + WinW'(1);
        if (ro_edge && (cnt_base != '1)) begin
          cnt_d = cnt_base + COUNT_W'(1);
        end else begin
          cnt_d = cnt_base;
        end
        if (win_q == WinLast) begin
          state_d = StDecide;
        end
      end
      StDecide: begin
        last_count_d  = cnt_q;
        count_valid_d = 1'b1;
        shift_d       = shift_nxt;
        bit_idx_d     = bit_idx_q + BitW'(1);
        if (bit_idx_q == BitLast) begin
          state_d       = StHold;
          frame_data_d  = shift_nxt;
          frame_valid_d = 1'b1;
        end else begin
          state_d = StMeasure;
          win_d   = '0;
        end
      end
      StHold: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          if (cont) begin
            state_d   = StMeasure;
            win_d     = '0;
            bit_idx_d = '0;
            shift_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    sensor_en   = (state_q == StMeasure) || (state_q == StDecide);
    busy        = (state_q != StIdle);
    last_count  = last_count_q;
    count_valid = count_valid_q;
    frame_data  = frame_data_q;
    frame_valid = frame_valid_q;
  end

endmodule
